// File: rtl/lsu_align.sv
// Load/store alignment unit: turns one request into word-aligned bus beats and right-justifies load data.
// Define LSU_MISALIGNED_EN to split misaligned accesses into two beats; otherwise they fault without a bus beat.

package lsu_align_pkg;
  typedef enum logic [1:0] {
    SEXT_WIDTH_8  = 2'd0,
    SEXT_WIDTH_16 = 2'd1,
    SEXT_WIDTH_32 = 2'd2
  } sext_width_t;
endpackage

module lsu_align
  import lsu_align_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output sext_width_t rsp_width,
  output logic        rsp_fault,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  // state | meaning
  // IDLE  | ready for a request
  // ISSUE | beat presented, bus_req held until granted
  // WAIT  | beat granted, waiting for bus_rvalid
  // RESP  | response held until rsp_ready
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [CW-1:0] cnt;
  logic [1:0]  a_off;
  logic [1:0]  a_size;
  logic        a_we;
  sext_width_t a_width;

  logic [1:0]  off;
  logic [4:0]  sh;
  logic [3:0]  mask;
  logic        misaligned;
  logic        bad_size;
  sext_width_t width;
  logic [3:0]  be0;
  logic [31:0] wd0;
  logic [63:0] rd_ext;
  logic [31:0] rd_shift;
  logic [31:0] rd_mask;
  logic [31:0] rd_val;

  assign off        = req_addr[1:0];
  assign sh         = {off, 3'b000};
  assign bad_size   = (req_size == 2'd3);
  assign misaligned = (req_size == 2'd1 && off == 2'd3) || (req_size == 2'd2 && off != 2'd0);

  always_comb begin
    mask = 4'h1;
    case (req_size)
      2'd1:    mask = 4'h3;
      2'd2:    mask = 4'hF;
      default: mask = 4'h1;
    endcase
  end

  always_comb begin
    width = SEXT_WIDTH_32;
    if (!req_we && !req_unsigned) begin
      if (req_size == 2'd0)      width = SEXT_WIDTH_8;
      else if (req_size == 2'd1) width = SEXT_WIDTH_16;
    end
  end

`ifdef LSU_MISALIGNED_EN
  logic [3:0]  be1;
  logic [31:0] wd1;
  logic        split;
  logic        beat1;
  logic [3:0]  b1_be;
  logic [31:0] b1_wdata;
  logic [31:0] b0_rdata;

  // Spill-over lanes of the shifted enables/data form the second beat.
  assign {be1, be0} = {4'h0, mask} << off;
  assign {wd1, wd0} = {32'h0, req_wdata} << sh;
  assign rd_ext     = beat1 ? {bus_rdata, b0_rdata} : {32'h0, bus_rdata};
`else
  assign be0    = mask << off;
  assign wd0    = req_wdata << sh;
  assign rd_ext = {32'h0, bus_rdata};
`endif

  assign rd_shift = 32'(rd_ext >> {a_off, 3'b000});

  always_comb begin
    rd_mask = 32'hFFFF_FFFF;
    case (a_size)
      2'd0:    rd_mask = 32'h0000_00FF;
      2'd1:    rd_mask = 32'h0000_FFFF;
      default: rd_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign rd_val = rd_shift & rd_mask;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= '0;
      rsp_width <= SEXT_WIDTH_32;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      a_off     <= '0;
      a_size    <= '0;
      a_we      <= 1'b0;
      a_width   <= SEXT_WIDTH_32;
`ifdef LSU_MISALIGNED_EN
      split     <= 1'b0;
      beat1     <= 1'b0;
      b1_be     <= '0;
      b1_wdata  <= '0;
      b0_rdata  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_off     <= off;
            a_size    <= req_size;
            a_we      <= req_we;
            a_width   <= width;
            cnt       <= '0;
            req_ready <= 1'b0;
`ifdef LSU_MISALIGNED_EN
            if (bad_size) begin
`else
            if (bad_size || misaligned) begin
`endif
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
              rsp_rdata <= '0;
              rsp_width <= width;
            end else begin
              state     <= ISSUE;
              bus_req   <= 1'b1;
              bus_we    <= req_we;
              bus_addr  <= {req_addr[31:2], 2'b00};
              bus_be    <= be0;
              bus_wdata <= wd0;
`ifdef LSU_MISALIGNED_EN
              split     <= misaligned;
              beat1     <= 1'b0;
              b1_be     <= be1;
              b1_wdata  <= wd1;
`endif
            end
          end
        end
        ISSUE: begin
          if (bus_gnt) begin
            state   <= WAIT;
            bus_req <= 1'b0;
            cnt     <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= RESP;
            bus_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b1;
            rsp_rdata <= '0;
            rsp_width <= a_width;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          // A completion arriving on the terminal count still wins over the timeout.
          if (bus_rvalid && bus_err) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b1;
            rsp_rdata <= '0;
            rsp_width <= a_width;
`ifdef LSU_MISALIGNED_EN
          end else if (bus_rvalid && split && !beat1) begin
            state     <= ISSUE;
            bus_req   <= 1'b1;
            bus_addr  <= bus_addr + 32'd4;
            bus_be    <= b1_be;
            bus_wdata <= b1_wdata;
            beat1     <= 1'b1;
            b0_rdata  <= bus_rdata;
            cnt       <= '0;
`endif
          end else if (bus_rvalid) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b0;
            rsp_rdata <= a_we ? 32'h0 : rd_val;
            rsp_width <= a_width;
          end else if (cnt == CNT_LAST) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b1;
            rsp_rdata <= '0;
            rsp_width <= a_width;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a cycle-stepped bus/response model and hand-computed expectations.
// Misaligned vectors expect splitting when LSU_MISALIGNED_EN is defined and a fault otherwise.

module tb_lsu_align;
  import lsu_align_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  sext_width_t rsp_width;
  logic        rsp_fault;
  logic        bus_req;
  logic        bus_gnt;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  // bus model settings and captured results of the last access
  logic [31:0] rd [2];
  logic        er [2];
  int          gnt_dly, rv_dly, rsp_dly;
  int          nb, r_lat;
  logic [31:0] ba [2];
  logic [3:0]  bbe [2];
  logic [31:0] bwd [2];
  logic        bwe [2];
  logic [31:0] r_rdata;
  sext_width_t r_width;
  logic        r_fault;

  lsu_align #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_width(rsp_width), .rsp_fault(rsp_fault),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic setbus(input logic [31:0] d0, input logic [31:0] d1, input logic e0,
                        input logic e1, input int gd, input int rvd, input int rspd);
    rd[0] = d0; rd[1] = d1; er[0] = e0; er[1] = e1;
    gnt_dly = gd; rv_dly = rvd; rsp_dly = rspd;
  endtask

  // Drives one request, serves every beat the DUT presents and takes the response.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int  lat;
    int  k;
    bit  got;
    nb = 0; got = 0; r_lat = 0;
    check_eq("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    tick;
    req_valid = 1'b0;
    lat = 1;
    while (!got && lat < 100) begin
      if (rsp_valid) begin
        r_lat = lat;
        repeat (rsp_dly) tick;
        r_rdata = rsp_rdata; r_width = rsp_width; r_fault = rsp_fault;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        got = 1;
      end else if (bus_req) begin
        k = (nb < 2) ? nb : 1;
        for (int i = 0; i < gnt_dly; i++) begin tick; lat++; end
        ba[k] = bus_addr; bbe[k] = bus_be; bwd[k] = bus_wdata; bwe[k] = bus_we;
        bus_gnt = 1'b1;
        tick; lat++;
        bus_gnt = 1'b0;
        for (int i = 0; i < rv_dly; i++) begin tick; lat++; end
        bus_rvalid = 1'b1; bus_rdata = rd[k]; bus_err = er[k];
        tick; lat++;
        bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
        nb++;
      end else begin
        tick; lat++;
      end
    end
    if (!got) check_eq("rsp_wait", 32'd0, 32'd1);
  endtask

  task automatic check_rsp(input string t, input int exp_nb, input logic [31:0] exp_rdata,
                           input logic exp_fault, input int exp_lat);
    check_eq({t, "_nbeats"}, nb, exp_nb);
    check_eq({t, "_rdata"}, r_rdata, exp_rdata);
    check_eq({t, "_fault"}, {31'b0, r_fault}, {31'b0, exp_fault});
    check_eq({t, "_lat"}, r_lat, exp_lat);
  endtask

  task automatic check_beat(input string t, input int i, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wd, input logic we);
    check_eq({t, "_addr"}, ba[i], addr);
    check_eq({t, "_be"}, {28'b0, bbe[i]}, {28'b0, be});
    check_eq({t, "_wdata"}, bwd[i], wd);
    check_eq({t, "_we"}, {31'b0, bwe[i]}, {31'b0, we});
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    setbus(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick;

    check_eq("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_fault", {31'b0, rsp_fault}, 32'd0);
    check_eq("rst_bus_req", {31'b0, bus_req}, 32'd0);
    check_eq("rst_bus_we", {31'b0, bus_we}, 32'd0);
    check_eq("rst_bus_addr", bus_addr, 32'd0);
    check_eq("rst_bus_be", {28'b0, bus_be}, 32'd0);
    check_eq("rst_bus_wdata", bus_wdata, 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_rsp_width", rsp_width, SEXT_WIDTH_32);
    rst_n = 1'b1;
    tick;

    // signed byte load at offset 3
    setbus(32'h80FF_FFFF, 0, 0, 0, 0, 0, 0);
    access(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0);
    check_rsp("lb", 1, 32'h0000_0080, 1'b0, 3);
    check_eq("lb_width", r_width, SEXT_WIDTH_8);
    check_beat("lb", 0, 32'h0000_1000, 4'h8, 32'h0, 1'b0);

    // unsigned half load
    setbus(32'hBEEF_0000, 0, 0, 0, 0, 0, 0);
    access(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0);
    check_rsp("lhu", 1, 32'h0000_BEEF, 1'b0, 3);
    check_eq("lhu_width", r_width, SEXT_WIDTH_32);
    check_beat("lhu", 0, 32'h0000_2000, 4'hC, 32'h0, 1'b0);

    // signed half load, offset 0
    setbus(32'h1234_8765, 0, 0, 0, 0, 0, 0);
    access(1'b0, 2'd1, 1'b0, 32'h0000_2000, 32'h0);
    check_rsp("lh", 1, 32'h0000_8765, 1'b0, 3);
    check_eq("lh_width", r_width, SEXT_WIDTH_16);
    check_eq("lh_be", {28'b0, bbe[0]}, 32'h3);

    // half at offset 1 stays within the word
    setbus(32'h00AB_CD00, 0, 0, 0, 0, 0, 0);
    access(1'b0, 2'd1, 1'b1, 32'h0000_8001, 32'h0);
    check_rsp("lhu_off1", 1, 32'h0000_ABCD, 1'b0, 3);
    check_eq("lhu_off1_be", {28'b0, bbe[0]}, 32'h6);

    // grant and completion each on the last cycle before timeout, slow rsp_ready
    setbus(32'h0102_0304, 0, 0, 0, 3, 3, 2);
    access(1'b0, 2'd2, 1'b0, 32'h0000_7000, 32'h0);
    check_rsp("lw_slow", 1, 32'h0102_0304, 1'b0, 9);
    check_eq("lw_slow_width", r_width, SEXT_WIDTH_32);
    check_beat("lw_slow", 0, 32'h0000_7000, 4'hF, 32'h0, 1'b0);

    // stores: read data on the completing beat must not leak into rsp_rdata
    setbus(32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    access(1'b1, 2'd2, 1'b0, 32'h0000_4000, 32'hAABB_CCDD);
    check_rsp("sw", 1, 32'h0, 1'b0, 3);
    check_eq("sw_width", r_width, SEXT_WIDTH_32);
    check_beat("sw", 0, 32'h0000_4000, 4'hF, 32'hAABB_CCDD, 1'b1);

    access(1'b1, 2'd0, 1'b0, 32'h0000_5001, 32'h1234_56A5);
    check_rsp("sb", 1, 32'h0, 1'b0, 3);
    check_beat("sb", 0, 32'h0000_5000, 4'h2, 32'h3456_A500, 1'b1);

    access(1'b1, 2'd1, 1'b0, 32'h0000_6002, 32'hCAFE_BEEF);
    check_rsp("sh", 1, 32'h0, 1'b0, 3);
    check_beat("sh", 0, 32'h0000_6000, 4'hC, 32'hBEEF_0000, 1'b1);

    // illegal size: no beat, fault one cycle after accept
    access(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0);
    check_rsp("bad_size", 0, 32'h0, 1'b1, 1);

    // bus error on an aligned load
    setbus(32'hDEAD_BEEF, 0, 1, 0, 0, 0, 0);
    access(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0);
    check_rsp("berr", 1, 32'h0, 1'b1, 3);

    // completion one cycle too late: fault, late rvalid lands in RESP and is ignored
    setbus(32'h1234_5678, 0, 0, 0, 0, 4, 0);
    access(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0);
    check_eq("wait_to_fault", {31'b0, r_fault}, 32'd1);
    check_eq("wait_to_rdata", r_rdata, 32'h0);

`ifdef LSU_MISALIGNED_EN
    setbus(0, 0, 0, 0, 0, 0, 0);
    access(1'b1, 2'd2, 1'b0, 32'h0000_3001, 32'hAABB_CCDD);
    check_rsp("sw_mis", 2, 32'h0, 1'b0, 5);
    check_beat("sw_mis_b0", 0, 32'h0000_3000, 4'hE, 32'hBBCC_DD00, 1'b1);
    check_beat("sw_mis_b1", 1, 32'h0000_3004, 4'h1, 32'h0000_00AA, 1'b1);

    setbus(32'h1122_0000, 32'h0000_3344, 0, 0, 0, 0, 0);
    access(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0);
    check_rsp("lw_wrap", 2, 32'h3344_1122, 1'b0, 5);
    check_eq("lw_wrap_a0", ba[0], 32'hFFFF_FFFC);
    check_eq("lw_wrap_a1", ba[1], 32'h0000_0000);
    check_eq("lw_wrap_be0", {28'b0, bbe[0]}, 32'hC);
    check_eq("lw_wrap_be1", {28'b0, bbe[1]}, 32'h3);

    setbus(32'hAB00_0000, 32'h0000_00CD, 0, 0, 0, 0, 0);
    access(1'b0, 2'd1, 1'b0, 32'h0000_8003, 32'h0);
    check_rsp("lh_mis", 2, 32'h0000_CDAB, 1'b0, 5);
    check_eq("lh_mis_width", r_width, SEXT_WIDTH_16);
    check_eq("lh_mis_be0", {28'b0, bbe[0]}, 32'h8);
    check_eq("lh_mis_be1", {28'b0, bbe[1]}, 32'h1);

    // error on the first beat of a split access skips the second beat
    setbus(32'h5555_5555, 32'h6666_6666, 1, 0, 0, 0, 0);
    access(1'b0, 2'd2, 1'b0, 32'h0000_3002, 32'h0);
    check_rsp("berr_split", 1, 32'h0, 1'b1, 3);
`else
    setbus(32'h5555_5555, 32'h6666_6666, 0, 0, 0, 0, 0);
    access(1'b1, 2'd2, 1'b0, 32'h0000_3001, 32'hAABB_CCDD);
    check_rsp("sw_mis", 0, 32'h0, 1'b1, 1);
    access(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0);
    check_rsp("lw_mis", 0, 32'h0, 1'b1, 1);
    access(1'b0, 2'd1, 1'b0, 32'h0000_8003, 32'h0);
    check_rsp("lh_mis", 0, 32'h0, 1'b1, 1);
`endif

    // grant never arrives: bus_req stays up for exactly TIMEOUT_CYCLES cycles
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0000_9000; req_wdata = '0;
    tick;
    req_valid = 1'b0;
    n = 0;
    while (bus_req && n < 20) begin n++; tick; end
    check_eq("to_req_cycles", n, 4);
    check_eq("to_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check_eq("to_rsp_fault", {31'b0, rsp_fault}, 32'd1);
    check_eq("to_rsp_rdata", rsp_rdata, 32'h0);
    bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
    tick;
    bus_rvalid = 1'b0; bus_rdata = '0;
    check_eq("to_hold_valid", {31'b0, rsp_valid}, 32'd1);
    check_eq("to_hold_rdata", rsp_rdata, 32'h0);
    check_eq("to_hold_fault", {31'b0, rsp_fault}, 32'd1);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h7777_7777;
    tick;
    bus_rvalid = 1'b0; bus_rdata = '0;
    check_eq("to_idle_ready", {31'b0, req_ready}, 32'd1);
    check_eq("to_idle_rsp", {31'b0, rsp_valid}, 32'd0);
    check_eq("to_idle_bus_req", {31'b0, bus_req}, 32'd0);

    // reset while a beat is being requested
    req_valid = 1'b1; req_addr = 32'h0000_A000; req_size = 2'd2; req_we = 1'b0;
    tick;
    req_valid = 1'b0;
    check_eq("rst_issue_busy", {31'b0, req_ready}, 32'd0);
    check_eq("rst_issue_req", {31'b0, bus_req}, 32'd1);
    rst_n = 1'b0;
    tick;
    check_eq("rst_issue_req_drop", {31'b0, bus_req}, 32'd0);
    check_eq("rst_issue_ready", {31'b0, req_ready}, 32'd1);
    rst_n = 1'b1;
    tick;

    // reset while waiting for completion, stale completion afterwards
    req_valid = 1'b1; req_addr = 32'h0000_A004;
    tick;
    req_valid = 1'b0;
    bus_gnt = 1'b1;
    tick;
    bus_gnt = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check_eq("rst_wait_req", {31'b0, bus_req}, 32'd0);
    check_eq("rst_wait_rsp", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst_wait_ready", {31'b0, req_ready}, 32'd1);
    bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    tick;
    bus_rvalid = 1'b0; bus_rdata = '0;
    check_eq("stale_rsp", {31'b0, rsp_valid}, 32'd0);
    setbus(32'h0BAD_F00D, 0, 0, 0, 0, 0, 0);
    access(1'b0, 2'd2, 1'b0, 32'h0000_A008, 32'h0);
    check_rsp("after_rst", 1, 32'h0BAD_F00D, 1'b0, 3);
    check_beat("after_rst", 0, 32'h0000_A008, 4'hF, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit between the execute stage and the data bus. It accepts one memory request at a time and issues word-aligned bus beats with byte enables, splitting a misaligned access into two beats. Load data is returned right-justified with a `sext_width_t` tag, so the downstream sign-extension stage produces the final register value. Bus errors and bus timeouts are reported as a fault on the response.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles a beat may wait for `bus_gnt`, or after grant for `bus_rvalid`, before it is aborted with a fault.

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid` in 1 / `req_ready` out 1  request handshake
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and faults
- `req_unsigned`  in  1  load is zero-extended (LBU/LHU)
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-justified
- `rsp_valid` out 1 / `rsp_ready` in 1  response handshake
- `rsp_rdata`  out  32  load data, right-justified, upper bits zero
- `rsp_width`  out  `sext_width_t`  `SEXT_WIDTH_8` or `_16` for signed byte or half loads; `SEXT_WIDTH_32` otherwise
- `rsp_fault`  out  1  bus error, timeout, illegal size, or (macro off) misalignment
- `bus_req` out 1 / `bus_gnt` in 1  beat request, held until granted
- `bus_we`  out  1;  `bus_addr`  out  32, always `[1:0]=0`;  `bus_be`  out  4;  `bus_wdata`  out  32
- `bus_rvalid`  in  1  beat completion, for reads and writes; `bus_rdata` in 32; `bus_err` in 1, qualified by `bus_rvalid`

## Operation
- States:
  - IDLE → ISSUE: on request accept, capture `addr`, `size`, `we`, `unsigned` and `wdata`.
  - ISSUE (`bus_req`=1) → WAIT: on `bus_gnt`.
  - WAIT → ISSUE: on `bus_rvalid` when a second beat is pending.
  - WAIT → RESP: on `bus_rvalid` with no beat pending, or with `bus_err`.
  - RESP → IDLE: on `rsp_ready`.
- `req_ready` = (state == IDLE). Only one access is outstanding.
- Let `off` = `addr[1:0]` and `mask` = 1, 3 or F for byte, half or word.
- An access is misaligned when half has `off`=3, or word has `off`≠0. Byte accesses are never misaligned.
- Beat 0:
  - `bus_addr` = `addr & ~3`
  - `bus_be` = `(mask << off)[3:0]`
  - `bus_wdata` = `wdata << 8*off`
- Beat 1 (split only):
  - `bus_addr` = beat-0 address + 4, wrapping 0xFFFFFFFC → 0x00000000.
  - `bus_be` = `mask >> (4-off)`
  - `bus_wdata` = `wdata >> 8*(4-off)`
- Load assembly: `{beat1_rdata, beat0_rdata} >> 8*off`, masked to the size. For an unsplit access, beat-1 data is treated as 0.
- Stores return `rsp_rdata`=0 and `rsp_width`=`SEXT_WIDTH_32`.
- Fault handling:
  - `bus_err` on beat 0 skips beat 1.
  - Any fault forces `rsp_rdata`=0 and `rsp_fault`=1.
  - An illegal size goes IDLE → RESP without any bus beat.
- Timeout:
  - The counter clears on entry to ISSUE and on entry to WAIT, and increments each cycle in those states.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to RESP with a fault and `bus_req` drops.
  - A late `bus_rvalid` seen in IDLE or RESP is ignored.

## Timing
- Reset values: state IDLE; `req_ready`=1; `rsp_valid`, `rsp_fault`, `bus_req`, `bus_we`=0; `bus_addr`, `bus_be`, `bus_wdata`, `rsp_rdata`=0; `rsp_width`=`SEXT_WIDTH_32`; counter=0.
- All outputs are registered.
- Aligned access, zero-wait bus:
  - accept at edge N;
  - `bus_req`=1 during cycle N+1, granted;
  - `bus_rvalid` in cycle N+2;
  - `rsp_valid`=1 in cycle N+3.
- A split access adds 2 cycles.
- `rsp_*` are held stable while `rsp_valid` && !`rsp_ready`.
- `bus_*` outputs are held stable while `bus_req` && !`bus_gnt`.
- `rst_n` low mid-access: at the next edge the FSM returns to IDLE, `bus_req` and `rsp_valid` drop, and the pending access is discarded.
- `bus_rvalid` in the same cycle the counter reaches `TIMEOUT_CYCLES`: `bus_rvalid` wins and no fault is raised.

## Configuration
- `LSU_MISALIGNED_EN` defined: misaligned accesses are split into two beats as above.
- Undefined: a misaligned request issues no bus beat. It goes IDLE → RESP and returns `rsp_fault`=1 with `rsp_rdata`=0 one cycle after accept. The beat-1 logic is removed.

## Test plan
- Signed byte load, addr 0x1003, `bus_rdata` 0x80FFFFFF → `bus_be`=0x8; `rsp_rdata`=0x00000080; `rsp_width`=`SEXT_WIDTH_8`; `rsp_valid` 3 cycles after accept.
- Unsigned half load, addr 0x2002, `bus_rdata` 0xBEEF0000 → `rsp_rdata`=0x0000BEEF, `rsp_width`=`SEXT_WIDTH_32`.
- With macro: word store 0xAABBCCDD at 0x3001 → beat 0 at 0x3000 with be 0xE and wdata 0xBBCCDD00; beat 1 at 0x3004 with be 0x1 and wdata 0x000000AA.
- With macro: word load at 0xFFFFFFFE, beats 0x11220000 then 0x00003344 → second `bus_addr`=0x00000000; `rsp_rdata`=0x33441122.
- `bus_gnt` held low with `TIMEOUT_CYCLES`=4 → `bus_req` drops after 4 cycles; `rsp_fault`=1; `rsp_rdata`=0. A later `bus_rvalid` is ignored.
- Reset asserted during WAIT, then a new aligned load issued → `bus_req`=0 one edge after reset; the stale `bus_rvalid` is ignored; the new load returns the correct data.
